// File: rtl/pellet_map_controller.sv
// pellet_map_controller: maze pellet map owner, layout loader, pellet counter and power-pellet blinker
module pellet_map_controller #(
  parameter int COLS = 28,
  parameter int ROWS = 31,
  parameter int BLINK_FRAMES = 16,
  parameter int AW = 10,
  parameter int CNTW = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   layout_addr,
  input  logic [1:0]      layout_data,
  input  logic            disp_active,
  input  logic [4:0]      tile_col,
  input  logic [4:0]      tile_row,
  input  logic            frame_tick,
  output logic [1:0]      pix_sprite,
  input  logic            eat_req,
  input  logic [4:0]      eat_col,
  input  logic [4:0]      eat_row,
  output logic            eat_ack,
  output logic [1:0]      eat_kind,
  output logic [CNTW-1:0] pellets_left,
  output logic            level_clear,
  output logic            ready
);
  localparam int N = COLS * ROWS;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_FRAMES - 1);
  localparam logic [AW-1:0] LAST = AW'(N);
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [1:0] map [0:(1<<AW)-1];
  logic [1:0] rdata, wdata, lay;
  logic [AW-1:0] idx, ram_addr, tile_addr, eat_addr;
  logic [BW-1:0] bcnt;
  logic [CNTW-1:0] cnt_nxt;
  logic we, tile_ok, eat_ok, eat_busy, accept, raster_v, phase, fin, dec;
  assign tile_ok = 32'(tile_col) < COLS && 32'(tile_row) < ROWS;
  assign eat_ok = 32'(eat_col) < COLS && 32'(eat_row) < ROWS;
  assign tile_addr = AW'(32'(tile_row) * COLS + 32'(tile_col));
  assign eat_addr = AW'(32'(eat_row) * COLS + 32'(eat_col));
  assign lay = layout_data == 2'd3 ? 2'd0 : layout_data;
  assign fin = state == INIT && idx == LAST && !start;
  assign accept = state == RUN && !disp_active && eat_req && !eat_busy && !start;
  assign dec = state == RUN && eat_busy && eat_ok && rdata != 2'd0 && pellets_left != '0;
  assign ready = state == RUN;
  assign eat_ack = eat_busy;
  assign eat_kind = eat_busy && eat_ok ? rdata : 2'd0;
  assign layout_addr = state == INIT && idx != LAST ? idx : '0;
  assign pix_sprite = raster_v && !(rdata == 2'd2 && phase) ? rdata : 2'd0;
  // Next state: start always (re)enters INIT; INIT ends once the last tile is written
  always_comb begin
    state_nxt = start ? INIT : fin ? RUN : state;
    cnt_nxt = start ? '0 : (state == INIT && idx != '0 && lay != 2'd0) ? pellets_left + CNTW'(1) : dec ? pellets_left - CNTW'(1) : pellets_left;
  end
  // Single map port arbitration: INIT load, then eat (read/write-back), then raster read
  always_comb begin
    ram_addr = '0;
    we = 1'b0;
    wdata = 2'd0;
    if (state == INIT && idx != '0) begin
      ram_addr = idx - AW'(1);
      we = 1'b1;
      wdata = lay;
    end else if (state == RUN && (eat_busy || accept)) begin
      ram_addr = eat_ok ? eat_addr : '0;
      we = dec;
    end else if (state == RUN && disp_active && tile_ok) begin
      ram_addr = tile_addr;
    end
  end
  // Map RAM: contents are undefined until INIT has written every tile
  always_ff @(posedge clk) begin
    if (we) map[ram_addr] <= wdata;
    rdata <= map[ram_addr];
  end
  // Control state, load index, eat/raster pipeline flags, pellet count and blink phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      eat_busy <= 1'b0;
      raster_v <= 1'b0;
      pellets_left <= '0;
      level_clear <= 1'b0;
      phase <= 1'b0;
      bcnt <= '0;
    end else begin
      state <= state_nxt;
      idx <= (!start && state == INIT && idx != LAST) ? idx + AW'(1) : '0;
      eat_busy <= accept;
      raster_v <= state == RUN && !start && disp_active && tile_ok && !eat_busy;
      pellets_left <= cnt_nxt;
      level_clear <= (fin || (dec && !start)) && cnt_nxt == '0;
      if (start) begin
        phase <= 1'b0;
        bcnt <= '0;
      end else if (state == RUN && frame_tick) begin
        bcnt <= bcnt == BMAX ? '0 : bcnt + BW'(1);
        phase <= bcnt == BMAX ? ~phase : phase;
      end
    end
  end
endmodule

// File: tb/tb_pellet_map_controller.sv
// tb_pellet_map_controller: directed self-checking bench for pellet_map_controller
module tb_pellet_map_controller;
  localparam int N = 28 * 31;
  logic clk, reset, start, disp_active, frame_tick, eat_req;
  logic [9:0] layout_addr;
  logic [1:0] layout_data, pix_sprite, eat_kind;
  logic [4:0] tile_col, tile_row, eat_col, eat_row;
  logic eat_ack, level_clear, ready;
  logic [9:0] pellets_left;
  int total = 0;
  int bad = 0;

  pellet_map_controller dut (
    .clk(clk), .reset(reset), .start(start), .layout_addr(layout_addr), .layout_data(layout_data),
    .disp_active(disp_active), .tile_col(tile_col), .tile_row(tile_row), .frame_tick(frame_tick),
    .pix_sprite(pix_sprite), .eat_req(eat_req), .eat_col(eat_col), .eat_row(eat_row),
    .eat_ack(eat_ack), .eat_kind(eat_kind), .pellets_left(pellets_left),
    .level_clear(level_clear), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout ROM: pellets at addr 29,30,31 (row 1, cols 1..3), power at 61 (row 2, col 5), code 3 at 100
  always @(posedge clk)
    layout_data <= (layout_addr == 10'd29 || layout_addr == 10'd30 || layout_addr == 10'd31) ? 2'd1 :
                   layout_addr == 10'd61 ? 2'd2 : layout_addr == 10'd100 ? 2'd3 : 2'd0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_cnt"}, 32'(pellets_left), 0);
    chk({tag, "_laddr"}, 32'(layout_addr), 0);
    chk({tag, "_pix"}, 32'(pix_sprite), 0);
    chk({tag, "_ack"}, 32'(eat_ack), 0);
    chk({tag, "_kind"}, 32'(eat_kind), 0);
    chk({tag, "_clr"}, 32'(level_clear), 0);
  endtask

  task automatic eat(input logic [4:0] c, input logic [4:0] r, input int kind, input int cnt_before);
    eat_col = c;
    eat_row = r;
    eat_req = 1'b1;
    chk("eat_accept_noack", 32'(eat_ack), 0);
    step();
    chk("eat_ack", 32'(eat_ack), 1);
    chk("eat_kind", 32'(eat_kind), 32'(kind));
    chk("eat_cnt_during_ack", 32'(pellets_left), 32'(cnt_before));
    eat_req = 1'b0;
    step();
    chk("eat_ack_drop", 32'(eat_ack), 0);
    chk("eat_cnt_after", 32'(pellets_left), 32'(kind != 0 ? cnt_before - 1 : cnt_before));
  endtask

  task automatic load(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_laddr0"}, 32'(layout_addr), 0);
    step();
    chk({tag, "_laddr1"}, 32'(layout_addr), 1);
    repeat (N - 1) step();
    chk({tag, "_notready"}, 32'(ready), 0);
    step();
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_count"}, 32'(pellets_left), 4);
    chk({tag, "_noclr"}, 32'(level_clear), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; disp_active = 1'b0; frame_tick = 1'b0; eat_req = 1'b0;
    tile_col = '0; tile_row = '0; eat_col = '0; eat_row = '0;
    repeat (3) step();
    chk_idle("reset");
    reset = 1'b0;
    step();
    // 1: load layout
    load("load");
    // 2: raster reads
    disp_active = 1'b1; tile_col = 5'd1; tile_row = 5'd1;
    step(); chk("pix_pellet", 32'(pix_sprite), 1);
    tile_col = 5'd5; tile_row = 5'd2;
    step(); chk("pix_power", 32'(pix_sprite), 2);
    tile_col = 5'd16; tile_row = 5'd3;
    step(); chk("pix_code3_empty", 32'(pix_sprite), 0);
    tile_col = 5'd30; tile_row = 5'd1;
    step(); chk("pix_out_of_range", 32'(pix_sprite), 0);
    tile_col = 5'd5; tile_row = 5'd2;
    step(); chk("pix_power_again", 32'(pix_sprite), 2);
    // 3: blink
    frame_tick = 1'b1;
    repeat (15) step();
    chk("blink_15_ticks", 32'(pix_sprite), 2);
    step();
    frame_tick = 1'b0;
    chk("blink_off", 32'(pix_sprite), 0);
    tile_col = 5'd1; tile_row = 5'd1;
    step(); chk("blink_pellet_steady", 32'(pix_sprite), 1);
    tile_col = 5'd5; tile_row = 5'd2;
    frame_tick = 1'b1;
    repeat (16) step();
    frame_tick = 1'b0;
    chk("blink_on", 32'(pix_sprite), 2);
    disp_active = 1'b0;
    step(); chk("pix_blank", 32'(pix_sprite), 0);
    // 4: eat power tile, then re-eat it and an out-of-range tile
    eat(5'd5, 5'd2, 2, 4);
    eat(5'd5, 5'd2, 0, 3);
    eat(5'd29, 5'd0, 0, 3);
    // 5: eat the rest; last one deferred while display is active
    eat(5'd1, 5'd1, 1, 3);
    eat(5'd2, 5'd1, 1, 2);
    disp_active = 1'b1;
    eat_col = 5'd3; eat_row = 5'd1; eat_req = 1'b1;
    repeat (3) begin
      step(); chk("eat_wait_disp", 32'(eat_ack), 0);
    end
    disp_active = 1'b0;
    eat(5'd3, 5'd1, 1, 1);
    chk("level_clear_pulse", 32'(level_clear), 1);
    step();
    chk("level_clear_once", 32'(level_clear), 0);
    chk("count_zero", 32'(pellets_left), 0);
    // 6: reset mid-INIT, then full reload
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("init_laddr5", 32'(layout_addr), 5);
    reset = 1'b1;
    #1;
    chk_idle("midinit_reset");
    step();
    reset = 1'b0;
    step();
    chk_idle("post_reset_idle");
    load("reload");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
